mem_responder: RTL and testbench

- Main-memory side of the cache-to-memory interface. Answers MStrobe/MRW requests from the cache controller FSM.
- Holds a word-addressed storage array. Completes each read or write after exactly LATENCY cycles. Pulses MRdy at completion.
- The fixed latency matches the controller's load-counter wait (LdCtr/CtrSig), so both ends agree on the cycle of completion.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_latency_ctr.sv | 26 ++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the main-memory responder.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int MEM_ADDR_W  = 8;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_LATENCY = 4;
  localparam int MEM_CNT_W   = 4;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter with zero flag; the memory-side twin of the controller's LdCtr/CtrSig counter.
module mem_latency_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;

  // Load wins over enable; the count saturates at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency word-addressed memory answering MStrobe/MRW requests with an MRdy pulse.
// Optional overlapping-request checker enabled by defining MEM_PROTOCOL_CHECK_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int LATENCY = MEM_LATENCY,
  parameter int CNT_W   = MEM_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MRdy,
  output logic              MBusy,
  output logic              ProtoErr,
  output logic [1:0]        o_dbg_state
);
  // Handshake: MStrobe is sampled only in IDLE; MBusy is high from the cycle
  // after acceptance through the single MRdy cycle; strobes while busy are dropped.
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_DONE   = DONE;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  logic w_accept;
  logic w_ctr_zero;
  logic w_enter_done;

  assign w_accept     = (r_state == S_IDLE) && MStrobe;
  assign w_enter_done = (r_state == S_ACCESS) && w_ctr_zero;

  mem_latency_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .i_en       (r_state == S_ACCESS),
    .o_zero     (w_ctr_zero)
  );

  // LATENCY=1 still passes through ACCESS with a zero count, keeping MRdy at T+LATENCY.
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:   w_next_state = MStrobe ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next_state = w_ctr_zero ? S_DONE : S_ACCESS;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rw    <= MEM_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_rw    <= MRW;
        r_addr  <= MAddr;
        r_wdata <= MDataIn;
      end
      if (w_enter_done && (r_rw == MEM_READ)) begin
        r_rdata <= r_mem[r_addr];
      end
    end
  end

  // Storage is not reset; a reset edge still suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_done && (r_rw == MEM_WRITE)) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

`ifdef MEM_PROTOCOL_CHECK_EN
  logic r_proto_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_proto_err <= 1'b0;
    end else if (MStrobe && (r_state != S_IDLE)) begin
      r_proto_err <= 1'b1;
    end
  end
  assign ProtoErr = r_proto_err;
`else
  assign ProtoErr = 1'b0;
`endif

  assign MRdy        = (r_state == S_DONE);
  assign MBusy       = (r_state == S_ACCESS) || (r_state == S_DONE);
  assign MDataOut    = r_rdata;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: edge-arithmetic reference model plus directed scenarios.
module tb_mem_responder;
  localparam int TB_LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MStrobe = 1'b0;
  logic        MRW = 1'b0;
  logic [7:0]  MAddr = '0;
  logic [31:0] MDataIn = '0;
  logic [31:0] MDataOut;
  logic        MRdy;
  logic        MBusy;
  logic        ProtoErr;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_fail = 0;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .LATENCY(TB_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .MStrobe(MStrobe), .MRW(MRW), .MAddr(MAddr),
    .MDataIn(MDataIn), .MDataOut(MDataOut), .MRdy(MRdy), .MBusy(MBusy),
    .ProtoErr(ProtoErr), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction accepted at edge A completes at edge A+LAT,
  // MRdy shows after that edge, and the next acceptance is possible from edge A+LAT+2.
  logic [31:0] m_mem [0:255];
  bit          m_known [0:255];
  int          edge_n = 0;
  int          acc = -1;
  bit          m_idle;
  logic        m_rw;
  logic [7:0]  m_addr;
  logic [31:0] m_wd;
  logic        exp_rdy = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] exp_dout = '0;
  bit          dout_known = 1'b1;
  logic        exp_perr = 1'b0;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      acc = -1; exp_rdy = 1'b0; exp_busy = 1'b0; exp_dout = '0;
      dout_known = 1'b1; exp_perr = 1'b0; model_valid = 1'b1;
    end else begin
      m_idle = (acc < 0) || (edge_n >= acc + TB_LAT + 2);
      if (acc >= 0 && edge_n == acc + TB_LAT) begin
        if (m_rw) begin
          m_mem[m_addr] = m_wd; m_known[m_addr] = 1'b1;
        end else begin
          exp_dout = m_mem[m_addr]; dout_known = m_known[m_addr];
        end
      end
`ifdef MEM_PROTOCOL_CHECK_EN
      if (MStrobe && !m_idle) exp_perr = 1'b1;
`endif
      if (m_idle && MStrobe) begin
        acc = edge_n; m_rw = MRW; m_addr = MAddr; m_wd = MDataIn;
      end
      exp_rdy  = (acc >= 0) && (edge_n == acc + TB_LAT);
      exp_busy = (acc >= 0) && (edge_n >= acc) && (edge_n <= acc + TB_LAT);
    end
    edge_n++;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("mrdy", 64'(MRdy), 64'(exp_rdy));
      chk("mbusy", 64'(MBusy), 64'(exp_busy));
      chk("perr", 64'(ProtoErr), 64'(exp_perr));
      if (dout_known) chk("mdataout", 64'(MDataOut), 64'(exp_dout));
    end
  end

  task automatic txn(input logic rw, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    int k;
    k = 0;
    @(negedge clk);
    MStrobe = 1'b1; MRW = rw; MAddr = a; MDataIn = d;
    do begin
      @(negedge clk);
      MStrobe = 1'b0;
      k++;
    end while (!MRdy && k < 40);
    chk("txn_latency", 64'(k), 64'(TB_LAT + 1));
    rd = MDataOut;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int k;
    int pulses;

    repeat (3) @(negedge clk);
    chk("rst_mrdy", 64'(MRdy), 64'd0);
    chk("rst_mbusy", 64'(MBusy), 64'd0);
    chk("rst_dout", 64'(MDataOut), 64'd0);
    chk("rst_perr", 64'(ProtoErr), 64'd0);
    reset = 1'b0;

    // Write then read back.
    txn(1'b1, 8'h10, 32'hDEADBEEF, rd);
    chk("write_keeps_dout", 64'(rd), 64'd0);
    txn(1'b0, 8'h10, 32'h0, rd);
    chk("read_10", 64'(rd), 64'hDEADBEEF);

    // Read after read: old data held until the second MRdy.
    txn(1'b1, 8'h01, 32'h11, rd);
    txn(1'b1, 8'h02, 32'h22, rd);
    txn(1'b0, 8'h01, 32'h0, rd);
    chk("read_01", 64'(rd), 64'h11);
    @(negedge clk);
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h02;
    k = 0;
    do begin
      @(negedge clk);
      MStrobe = 1'b0;
      k++;
      if (!MRdy) chk("hold_11", 64'(MDataOut), 64'h11);
    end while (!MRdy && k < 40);
    chk("read_02", 64'(MDataOut), 64'h22);
    @(negedge clk);

    // Strobe held high for 12 edges: two completions, each followed by a dead cycle.
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h01;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (MRdy) pulses++;
      if (i == 5 || i == 11) chk("dead_cycle", 64'(MBusy), 64'd0);
      if (i == 11) MStrobe = 1'b0;
    end
    chk("held_pulses", 64'(pulses), 64'd2);

    // Overlapping request during ACCESS is ignored.
    txn(1'b1, 8'h30, 32'h0BADF00D, rd);
    @(negedge clk);
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h10;
    @(negedge clk);
    MRW = 1'b1; MAddr = 8'h30; MDataIn = 32'hAAAA5555;
    k = 1;
    do begin
      @(negedge clk);
      MStrobe = 1'b0;
      k++;
    end while (!MRdy && k < 40);
    chk("overlap_latency", 64'(k), 64'(TB_LAT + 1));
    chk("overlap_read", 64'(MDataOut), 64'hDEADBEEF);
    @(negedge clk);
    txn(1'b0, 8'h30, 32'h0, rd);
    chk("word30_unchanged", 64'(rd), 64'h0BADF00D);
`ifdef MEM_PROTOCOL_CHECK_EN
    chk("perr_sticky", 64'(ProtoErr), 64'd1);
`else
    chk("perr_tied", 64'(ProtoErr), 64'd0);
`endif

    // Reset in the middle of a read aborts it.
    txn(1'b1, 8'h20, 32'h12345678, rd);
    @(negedge clk);
    MStrobe = 1'b1; MRW = 1'b0; MAddr = 8'h20;
    @(negedge clk);
    MStrobe = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mbusy", 64'(MBusy), 64'd0);
    chk("abort_dout", 64'(MDataOut), 64'd0);
    chk("abort_perr", 64'(ProtoErr), 64'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (MRdy) pulses++;
    end
    chk("abort_no_mrdy", 64'(pulses), 64'd0);
    txn(1'b0, 8'h20, 32'h0, rd);
    chk("read_20_kept", 64'(rd), 64'h12345678);

    // Randomized traffic, including overlaps and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 79) == 0);
      MStrobe = ($urandom_range(0, 2) != 0);
      MRW     = 1'($urandom_range(0, 1));
      MAddr   = 8'($urandom_range(0, 31));
      MDataIn = $urandom;
    end
    @(negedge clk);
    reset = 1'b0; MStrobe = 1'b0;
    repeat (TB_LAT + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
